// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM.
// Optional feature macro: MC_JAL_EN (enables JAL dispatch and state).
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_MEM_ADDR  = 4'd3;
  localparam logic [3:0] S_MEM_READ  = 4'd4;
  localparam logic [3:0] S_MEM_WB    = 4'd5;
  localparam logic [3:0] S_MEM_WRITE = 4'd6;
  localparam logic [3:0] S_R_EXEC    = 4'd7;
  localparam logic [3:0] S_R_WB      = 4'd8;
  localparam logic [3:0] S_ADDI_EXEC = 4'd9;
  localparam logic [3:0] S_ADDI_WB   = 4'd10;
  localparam logic [3:0] S_BRANCH    = 4'd11;
  localparam logic [3:0] S_JUMP      = 4'd12;
  localparam logic [3:0] S_JAL       = 4'd13;
  localparam logic [3:0] S_TRAP      = 4'd14;

  localparam logic [3:0] ALUOP_ADDI  = 4'b0001;
  localparam logic [3:0] ALUOP_ADD   = 4'b0010;
  localparam logic [3:0] ALUOP_RTYPE = 4'b1001;
  localparam logic [3:0] ALUOP_SUB   = 4'b1011;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // Moore control word; fetch and retire_on_ready are gated with mem_ready at the top.
  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       fetch;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       retire;
    logic       retire_on_ready;
  } ctrl_t;

  function automatic logic [3:0] dispatch(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: return S_MEM_ADDR;
      OP_RTYPE:     return S_R_EXEC;
      OP_ADDI:      return S_ADDI_EXEC;
      OP_BEQ:       return S_BRANCH;
      OP_J:         return S_JUMP;
`ifdef MC_JAL_EN
      OP_JAL:       return S_JAL;
`endif
      default:      return S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-control-word decoder for multicycle_control.
// Optional feature macro: MC_JAL_EN (adds the JAL control word).
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] state,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.fetch     = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RT;
        ctrl.mem_to_reg = M2R_MDR;
        ctrl.retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_req         = 1'b1;
        ctrl.mem_write       = 1'b1;
        ctrl.iord            = 1'b1;
        ctrl.retire_on_ready = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RD;
        ctrl.mem_to_reg = M2R_ALUOUT;
        ctrl.retire     = 1'b1;
      end
      S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADDI;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RT;
        ctrl.mem_to_reg = M2R_ALUOUT;
        ctrl.retire     = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.retire        = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.retire    = 1'b1;
      end
`ifdef MC_JAL_EN
      // PC already holds PC+4 from FETCH, so it is the link value.
      S_JAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RA;
        ctrl.mem_to_reg = M2R_PC;
        ctrl.retire     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: state register, dispatch, Mealy gating, illegal_op flag.
// Optional feature macro: MC_JAL_EN (opcode 0x03 dispatches to JAL instead of TRAP).
module multicycle_control
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IrWrite,
  output logic       PcWrite,
  output logic       PcWriteCond,
  output logic [1:0] PcSource,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [3:0] AluOp,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic       RegWrite,
  output logic       retire,
  output logic       illegal_op,
  output logic [3:0] dbg_state
);

  logic [3:0] state;
  logic [3:0] next_state;
  ctrl_t      ctrl;

  // Handshake: a memory request (mem_req) is held with stable address and
  // direction until the cycle mem_ready is high; that cycle completes it.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      next_state = S_FETCH;
      S_FETCH:     if (mem_ready) next_state = S_DECODE;
      S_DECODE:    next_state = dispatch(opcode);
      S_MEM_ADDR:  next_state = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) next_state = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) next_state = S_FETCH;
      S_R_EXEC:    next_state = S_R_WB;
      S_ADDI_EXEC: next_state = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: next_state = S_FETCH;
`ifdef MC_JAL_EN
      S_JAL:       next_state = S_FETCH;
`endif
      S_TRAP:      next_state = S_TRAP;
      default:     next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      illegal_op <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE && next_state == S_TRAP) illegal_op <= 1'b1;
    end
  end

  mc_ctrl_decode u_decode (
    .state (state),
    .ctrl  (ctrl)
  );

  assign mem_req     = ctrl.mem_req;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IorD        = ctrl.iord;
  assign IrWrite     = ctrl.fetch & mem_ready;
  assign PcWrite     = ctrl.pc_write | (ctrl.fetch & mem_ready);
  assign PcWriteCond = ctrl.pc_write_cond;
  assign PcSource    = ctrl.pc_source;
  assign AluSrcA     = ctrl.alu_src_a;
  assign AluSrcB     = ctrl.alu_src_b;
  assign AluOp       = ctrl.alu_op;
  assign RegDst      = ctrl.reg_dst;
  assign MemToReg    = ctrl.mem_to_reg;
  assign RegWrite    = ctrl.reg_write;
  // A waiting store must pulse retire only on its completing cycle.
  assign retire      = ctrl.retire | (ctrl.retire_on_ready & mem_ready);
  assign dbg_state   = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; follows MC_JAL_EN if defined.
module tb_multicycle_control;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_req, MemRead, MemWrite, IorD, IrWrite, PcWrite, PcWriteCond;
  logic [1:0] PcSource, AluSrcB, RegDst, MemToReg;
  logic       AluSrcA, RegWrite, retire, illegal_op;
  logic [3:0] AluOp, dbg_state;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .IrWrite(IrWrite), .PcWrite(PcWrite), .PcWriteCond(PcWriteCond),
    .PcSource(PcSource), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp),
    .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite), .retire(retire),
    .illegal_op(illegal_op), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // {mem_req,MemRead,MemWrite,IorD}_{IrWrite,PcWrite,PcWriteCond}_PcSource_AluSrcA_AluSrcB_AluOp_RegDst_MemToReg_{RegWrite,retire,illegal_op}
  logic [22:0] obs;
  assign obs = {mem_req, MemRead, MemWrite, IorD, IrWrite, PcWrite, PcWriteCond, PcSource,
                AluSrcA, AluSrcB, AluOp, RegDst, MemToReg, RegWrite, retire, illegal_op};

  localparam logic [22:0] V_ZERO     = 23'b0000_000_00_0_00_0000_00_00_000;
  localparam logic [22:0] V_FETCH_W  = 23'b1100_000_00_0_01_0010_00_00_000;
  localparam logic [22:0] V_FETCH_R  = 23'b1100_110_00_0_01_0010_00_00_000;
  localparam logic [22:0] V_DECODE   = 23'b0000_000_00_0_11_0010_00_00_000;
  localparam logic [22:0] V_MEM_ADDR = 23'b0000_000_00_1_10_0010_00_00_000;
  localparam logic [22:0] V_MEM_RD   = 23'b1101_000_00_0_00_0000_00_00_000;
  localparam logic [22:0] V_MEM_WB   = 23'b0000_000_00_0_00_0000_00_01_110;
  localparam logic [22:0] V_MEM_WR_W = 23'b1011_000_00_0_00_0000_00_00_000;
  localparam logic [22:0] V_MEM_WR_R = 23'b1011_000_00_0_00_0000_00_00_010;
  localparam logic [22:0] V_R_EXEC   = 23'b0000_000_00_1_00_1001_00_00_000;
  localparam logic [22:0] V_R_WB     = 23'b0000_000_00_0_00_0000_01_00_110;
  localparam logic [22:0] V_ADDI_EX  = 23'b0000_000_00_1_10_0001_00_00_000;
  localparam logic [22:0] V_ADDI_WB  = 23'b0000_000_00_0_00_0000_00_00_110;
  localparam logic [22:0] V_BRANCH   = 23'b0000_001_01_1_00_1011_00_00_010;
  localparam logic [22:0] V_JUMP     = 23'b0000_010_10_0_00_0000_00_00_010;
  localparam logic [22:0] V_JAL      = 23'b0000_010_10_0_00_0000_10_10_110;
  localparam logic [22:0] V_TRAP     = 23'b0000_000_00_0_00_0000_00_00_001;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc, ret_at, ret_cnt, ir_cnt;
  logic [22:0] exp_q[$];
  logic [3:0]  st_q[$];
  logic        rdy_q[$];
  logic [22:0] ev;
  logic [3:0]  es;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic r, input logic [3:0] s, input logic [22:0] v);
    rdy_q.push_back(r);
    st_q.push_back(s);
    exp_q.push_back(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 6'h00; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++; if (dbg_state !== S_IDLE) $display("FAIL reset_state got %0d want %0d", dbg_state, S_IDLE); else pass_cnt++;
    chk_cnt++; if (obs !== V_ZERO) $display("FAIL reset_ctrl got %b want %b", obs, V_ZERO); else pass_cnt++;
    rst_n = 1'b1;
    #1;
    chk_cnt++; if (dbg_state !== S_IDLE) $display("FAIL release_state got %0d want %0d", dbg_state, S_IDLE); else pass_cnt++;
    step();
    chk_cnt++; if (dbg_state !== S_FETCH) $display("FAIL first_fetch_state got %0d want %0d", dbg_state, S_FETCH); else pass_cnt++;
    chk_cnt++; if (obs !== V_FETCH_W) $display("FAIL first_fetch_ctrl got %b want %b", obs, V_FETCH_W); else pass_cnt++;
  endtask

  task automatic test_rtype();
    opcode = OP_RTYPE;
    push(1, S_FETCH, V_FETCH_R); push(1, S_DECODE, V_DECODE);
    push(1, S_R_EXEC, V_R_EXEC); push(1, S_R_WB, V_R_WB);
    cyc = 0; ret_at = 0; ret_cnt = 0;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front(); #1; cyc++;
      es = st_q.pop_front(); ev = exp_q.pop_front();
      chk_cnt++; if (dbg_state !== es) $display("FAIL rtype_state cyc=%0d got %0d want %0d", cyc, dbg_state, es); else pass_cnt++;
      chk_cnt++; if (obs !== ev) $display("FAIL rtype_ctrl cyc=%0d got %b want %b", cyc, obs, ev); else pass_cnt++;
      if (retire) begin ret_at = cyc; ret_cnt++; end
      step();
    end
    chk_cnt++; if (ret_at !== 4 || ret_cnt !== 1) $display("FAIL rtype_retire got cyc %0d x%0d want cyc 4 x1", ret_at, ret_cnt); else pass_cnt++;
    chk_cnt++; if (dbg_state !== S_FETCH) $display("FAIL rtype_return got %0d want %0d", dbg_state, S_FETCH); else pass_cnt++;
  endtask

  task automatic test_lw_wait();
    opcode = OP_LW;
    push(0, S_FETCH, V_FETCH_W); push(0, S_FETCH, V_FETCH_W); push(1, S_FETCH, V_FETCH_R);
    push(1, S_DECODE, V_DECODE); push(0, S_MEM_ADDR, V_MEM_ADDR);
    push(0, S_MEM_READ, V_MEM_RD); push(0, S_MEM_READ, V_MEM_RD); push(0, S_MEM_READ, V_MEM_RD);
    push(1, S_MEM_READ, V_MEM_RD); push(0, S_MEM_WB, V_MEM_WB);
    cyc = 0; ret_at = 0; ret_cnt = 0; ir_cnt = 0;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front(); #1; cyc++;
      es = st_q.pop_front(); ev = exp_q.pop_front();
      chk_cnt++; if (dbg_state !== es) $display("FAIL lw_state cyc=%0d got %0d want %0d", cyc, dbg_state, es); else pass_cnt++;
      chk_cnt++; if (obs !== ev) $display("FAIL lw_ctrl cyc=%0d got %b want %b", cyc, obs, ev); else pass_cnt++;
      if (retire) begin ret_at = cyc; ret_cnt++; end
      if (IrWrite) ir_cnt++;
      step();
    end
    chk_cnt++; if (ir_cnt !== 1) $display("FAIL lw_irwrite_pulses got %0d want 1", ir_cnt); else pass_cnt++;
    chk_cnt++; if (ret_at !== 10 || ret_cnt !== 1) $display("FAIL lw_retire got cyc %0d x%0d want cyc 10 x1", ret_at, ret_cnt); else pass_cnt++;
    chk_cnt++; if (dbg_state !== S_FETCH) $display("FAIL lw_return got %0d want %0d", dbg_state, S_FETCH); else pass_cnt++;
  endtask

  task automatic test_sw_wait();
    opcode = OP_SW;
    push(1, S_FETCH, V_FETCH_R); push(0, S_DECODE, V_DECODE); push(1, S_MEM_ADDR, V_MEM_ADDR);
    push(0, S_MEM_WRITE, V_MEM_WR_W); push(1, S_MEM_WRITE, V_MEM_WR_R);
    cyc = 0; ret_at = 0; ret_cnt = 0;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front(); #1; cyc++;
      es = st_q.pop_front(); ev = exp_q.pop_front();
      chk_cnt++; if (dbg_state !== es) $display("FAIL sw_state cyc=%0d got %0d want %0d", cyc, dbg_state, es); else pass_cnt++;
      chk_cnt++; if (obs !== ev) $display("FAIL sw_ctrl cyc=%0d got %b want %b", cyc, obs, ev); else pass_cnt++;
      if (retire) begin ret_at = cyc; ret_cnt++; end
      step();
    end
    chk_cnt++; if (ret_at !== 5 || ret_cnt !== 1) $display("FAIL sw_retire got cyc %0d x%0d want cyc 5 x1", ret_at, ret_cnt); else pass_cnt++;
    chk_cnt++; if (dbg_state !== S_FETCH) $display("FAIL sw_return got %0d want %0d", dbg_state, S_FETCH); else pass_cnt++;
  endtask

  task automatic test_addi();
    opcode = OP_ADDI;
    push(1, S_FETCH, V_FETCH_R); push(1, S_DECODE, V_DECODE);
    push(1, S_ADDI_EXEC, V_ADDI_EX); push(1, S_ADDI_WB, V_ADDI_WB);
    cyc = 0; ret_at = 0; ret_cnt = 0;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front(); #1; cyc++;
      es = st_q.pop_front(); ev = exp_q.pop_front();
      chk_cnt++; if (dbg_state !== es) $display("FAIL addi_state cyc=%0d got %0d want %0d", cyc, dbg_state, es); else pass_cnt++;
      chk_cnt++; if (obs !== ev) $display("FAIL addi_ctrl cyc=%0d got %b want %b", cyc, obs, ev); else pass_cnt++;
      if (retire) begin ret_at = cyc; ret_cnt++; end
      step();
    end
    chk_cnt++; if (ret_at !== 4 || ret_cnt !== 1) $display("FAIL addi_retire got cyc %0d x%0d want cyc 4 x1", ret_at, ret_cnt); else pass_cnt++;
  endtask

  task automatic test_beq_j();
    opcode = OP_BEQ;
    push(1, S_FETCH, V_FETCH_R); push(1, S_DECODE, V_DECODE); push(1, S_BRANCH, V_BRANCH);
    cyc = 0; ret_at = 0; ret_cnt = 0;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front(); #1; cyc++;
      es = st_q.pop_front(); ev = exp_q.pop_front();
      chk_cnt++; if (dbg_state !== es) $display("FAIL beq_state cyc=%0d got %0d want %0d", cyc, dbg_state, es); else pass_cnt++;
      chk_cnt++; if (obs !== ev) $display("FAIL beq_ctrl cyc=%0d got %b want %b", cyc, obs, ev); else pass_cnt++;
      if (retire) begin ret_at = cyc; ret_cnt++; end
      step();
    end
    chk_cnt++; if (ret_at !== 3 || ret_cnt !== 1) $display("FAIL beq_retire got cyc %0d x%0d want cyc 3 x1", ret_at, ret_cnt); else pass_cnt++;
    opcode = OP_J;
    push(1, S_FETCH, V_FETCH_R); push(0, S_DECODE, V_DECODE); push(1, S_JUMP, V_JUMP);
    cyc = 0; ret_at = 0; ret_cnt = 0;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front(); #1; cyc++;
      es = st_q.pop_front(); ev = exp_q.pop_front();
      chk_cnt++; if (dbg_state !== es) $display("FAIL j_state cyc=%0d got %0d want %0d", cyc, dbg_state, es); else pass_cnt++;
      chk_cnt++; if (obs !== ev) $display("FAIL j_ctrl cyc=%0d got %b want %b", cyc, obs, ev); else pass_cnt++;
      if (retire) begin ret_at = cyc; ret_cnt++; end
      step();
    end
    chk_cnt++; if (ret_at !== 3 || ret_cnt !== 1) $display("FAIL j_retire got cyc %0d x%0d want cyc 3 x1", ret_at, ret_cnt); else pass_cnt++;
    chk_cnt++; if (dbg_state !== S_FETCH) $display("FAIL j_return got %0d want %0d", dbg_state, S_FETCH); else pass_cnt++;
  endtask

  task automatic test_jal();
    opcode = OP_JAL;
    push(1, S_FETCH, V_FETCH_R); push(1, S_DECODE, V_DECODE);
`ifdef MC_JAL_EN
    push(1, S_JAL, V_JAL);
`else
    for (int i = 0; i < 20; i++) push(1, S_TRAP, V_TRAP);
`endif
    cyc = 0; ret_cnt = 0;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front(); #1; cyc++;
      es = st_q.pop_front(); ev = exp_q.pop_front();
      chk_cnt++; if (dbg_state !== es) $display("FAIL jal_state cyc=%0d got %0d want %0d", cyc, dbg_state, es); else pass_cnt++;
      chk_cnt++; if (obs !== ev) $display("FAIL jal_ctrl cyc=%0d got %b want %b", cyc, obs, ev); else pass_cnt++;
      if (retire) ret_cnt++;
      step();
    end
`ifdef MC_JAL_EN
    chk_cnt++; if (ret_cnt !== 1) $display("FAIL jal_retire got %0d want 1", ret_cnt); else pass_cnt++;
`else
    chk_cnt++; if (ret_cnt !== 0) $display("FAIL jal_trap_retire got %0d want 0", ret_cnt); else pass_cnt++;
    do_reset();
    chk_cnt++; if (dbg_state !== S_FETCH || illegal_op !== 1'b0) $display("FAIL jal_trap_recover got st %0d ill %b want st %0d ill 0", dbg_state, illegal_op, S_FETCH); else pass_cnt++;
`endif
  endtask

  task automatic test_trap();
    opcode = 6'h3F;
    push(1, S_FETCH, V_FETCH_R); push(0, S_DECODE, V_DECODE);
    for (int i = 0; i < 20; i++) push(i[0], S_TRAP, V_TRAP);
    cyc = 0; ret_cnt = 0;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front(); #1; cyc++;
      es = st_q.pop_front(); ev = exp_q.pop_front();
      chk_cnt++; if (dbg_state !== es) $display("FAIL trap_state cyc=%0d got %0d want %0d", cyc, dbg_state, es); else pass_cnt++;
      chk_cnt++; if (obs !== ev) $display("FAIL trap_ctrl cyc=%0d got %b want %b", cyc, obs, ev); else pass_cnt++;
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if (illegal_op !== 1'b0) $display("FAIL trap_reset_illegal got %b want 0", illegal_op); else pass_cnt++;
    chk_cnt++; if (dbg_state !== S_IDLE) $display("FAIL trap_reset_state got %0d want %0d", dbg_state, S_IDLE); else pass_cnt++;
    mem_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_abort();
    opcode = OP_SW;
    push(1, S_FETCH, V_FETCH_R); push(0, S_DECODE, V_DECODE);
    push(0, S_MEM_ADDR, V_MEM_ADDR); push(0, S_MEM_WRITE, V_MEM_WR_W);
    cyc = 0;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front(); #1; cyc++;
      es = st_q.pop_front(); ev = exp_q.pop_front();
      chk_cnt++; if (dbg_state !== es) $display("FAIL abort_state cyc=%0d got %0d want %0d", cyc, dbg_state, es); else pass_cnt++;
      chk_cnt++; if (obs !== ev) $display("FAIL abort_ctrl cyc=%0d got %b want %b", cyc, obs, ev); else pass_cnt++;
      step();
    end
    chk_cnt++; if (dbg_state !== S_MEM_WRITE || MemWrite !== 1'b1) $display("FAIL abort_hold got st %0d wr %b want st %0d wr 1", dbg_state, MemWrite, S_MEM_WRITE); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if (MemWrite !== 1'b0 || mem_req !== 1'b0) $display("FAIL abort_memwrite got wr %b req %b want 0 0", MemWrite, mem_req); else pass_cnt++;
    chk_cnt++; if (dbg_state !== S_IDLE) $display("FAIL abort_state_idle got %0d want %0d", dbg_state, S_IDLE); else pass_cnt++;
    chk_cnt++; if (obs !== V_ZERO) $display("FAIL abort_ctrl_zero got %b want %b", obs, V_ZERO); else pass_cnt++;
    step();
    rst_n = 1'b1;
    step();
    mem_ready = 1'b1; opcode = OP_RTYPE;
    #1;
    chk_cnt++; if (dbg_state !== S_FETCH || IrWrite !== 1'b1) $display("FAIL abort_refetch got st %0d ir %b want st %0d ir 1", dbg_state, IrWrite, S_FETCH); else pass_cnt++;
    step();
    chk_cnt++; if (dbg_state !== S_DECODE) $display("FAIL abort_decode got %0d want %0d", dbg_state, S_DECODE); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_wait();
    test_addi();
    test_beq_j();
    test_jal();
    test_trap();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

endmodule
